// File: rtl/ddc_pwr_det.sv
// Windowed I/Q power detector for a DDC channel output: mean and peak of I^2+Q^2
// over 2^LOG2N samples, presented through a valid/ready result port with overflow flag.
module ddc_pwr_det #(
  parameter int DW    = 16,
  parameter int LOG2N = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              DIN_OE,
  input  logic [DW-1:0]     DIN_I,
  input  logic [DW-1:0]     DIN_Q,
  output logic              PWR_VLD,
  input  logic              PWR_RDY,
  output logic [2*DW-1:0]   PWR_DAT,
  output logic [2*DW-1:0]   PEAK_DAT,
  output logic              OVF
);

  localparam int SW = 2*DW - 1;
  localparam int PW = 2*DW;
  localparam int AW = 2*DW + LOG2N;

  // stage 1: squares
  logic [DW-1:0]    abs_i_s, abs_q_s;
  logic [SW-1:0]    absx_i_s, absx_q_s;
  logic [SW-1:0]    isq_d, isq_q, qsq_d, qsq_q;
  logic             s1_vld_d, s1_vld_q;
  // stage 2: instantaneous power
  logic [PW-1:0]    p_d, p_q;
  logic             s2_vld_d, s2_vld_q;
  // stage 3: window integration
  logic [AW-1:0]    acc_sum_s, acc_d, acc_q;
  logic [PW-1:0]    max_new_s, max_d, max_q;
  logic [LOG2N-1:0] cnt_d, cnt_q;
  logic             res_vld_d, res_vld_q;
  logic [PW-1:0]    res_pwr_d, res_pwr_q, res_pk_d, res_pk_q;
  // output port
  logic             vld_d, vld_q, ovf_d, ovf_q;
  logic [PW-1:0]    pwr_d, pwr_q, pk_d, pk_q;

  // Magnitudes fit in DW unsigned bits even for the most negative input.
  always_comb begin
    abs_i_s  = DIN_I[DW-1] ? (DW'(0) - DIN_I) : DIN_I;
    abs_q_s  = DIN_Q[DW-1] ? (DW'(0) - DIN_Q) : DIN_Q;
    absx_i_s = {{(DW-1){1'b0}}, abs_i_s};
    absx_q_s = {{(DW-1){1'b0}}, abs_q_s};
    s1_vld_d = DIN_OE;
    if (DIN_OE) begin
      isq_d = absx_i_s * absx_i_s;
      qsq_d = absx_q_s * absx_q_s;
    end else begin
      isq_d = isq_q;
      qsq_d = qsq_q;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_vld_q <= 1'b0;
      isq_q    <= {SW{1'b0}};
      qsq_q    <= {SW{1'b0}};
    end else if (CLR) begin
      s1_vld_q <= 1'b0;
      isq_q    <= {SW{1'b0}};
      qsq_q    <= {SW{1'b0}};
    end else begin
      s1_vld_q <= s1_vld_d;
      isq_q    <= isq_d;
      qsq_q    <= qsq_d;
    end
  end

  // Stage 2 next state: the extra MSB absorbs the 2^(2*DW-1) corner case.
  always_comb begin
    s2_vld_d = s1_vld_q;
    if (s1_vld_q) begin
      p_d = {1'b0, isq_q} + {1'b0, qsq_q};
    end else begin
      p_d = p_q;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_vld_q <= 1'b0;
      p_q      <= {PW{1'b0}};
    end else if (CLR) begin
      s2_vld_q <= 1'b0;
      p_q      <= {PW{1'b0}};
    end else begin
      s2_vld_q <= s2_vld_d;
      p_q      <= p_d;
    end
  end

  // Integration: the last sample of a window is folded directly into the result.
  always_comb begin
    acc_sum_s = acc_q + {{LOG2N{1'b0}}, p_q};
    max_new_s = (p_q > max_q) ? p_q : max_q;
    acc_d     = acc_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    res_vld_d = 1'b0;
    res_pwr_d = res_pwr_q;
    res_pk_d  = res_pk_q;
    if (s2_vld_q) begin
      if (cnt_q == {LOG2N{1'b1}}) begin
        res_vld_d = 1'b1;
        res_pwr_d = acc_sum_s[AW-1:LOG2N];
        res_pk_d  = max_new_s;
        acc_d     = {AW{1'b0}};
        max_d     = {PW{1'b0}};
        cnt_d     = {LOG2N{1'b0}};
      end else begin
        acc_d     = acc_sum_s;
        max_d     = max_new_s;
        cnt_d     = cnt_q + LOG2N'(1);
      end
    end else begin
      res_vld_d = 1'b0;
    end
  end

  // Integration registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q     <= {AW{1'b0}};
      max_q     <= {PW{1'b0}};
      cnt_q     <= {LOG2N{1'b0}};
      res_vld_q <= 1'b0;
      res_pwr_q <= {PW{1'b0}};
      res_pk_q  <= {PW{1'b0}};
    end else if (CLR) begin
      acc_q     <= {AW{1'b0}};
      max_q     <= {PW{1'b0}};
      cnt_q     <= {LOG2N{1'b0}};
      res_vld_q <= 1'b0;
      res_pwr_q <= {PW{1'b0}};
      res_pk_q  <= {PW{1'b0}};
    end else begin
      acc_q     <= acc_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      res_vld_q <= res_vld_d;
      res_pwr_q <= res_pwr_d;
      res_pk_q  <= res_pk_d;
    end
  end

  // Output port: a result loads when the slot is empty or being drained, else it is dropped.
  always_comb begin
    vld_d = vld_q;
    pwr_d = pwr_q;
    pk_d  = pk_q;
    ovf_d = ovf_q;
    if (res_vld_q) begin
      if (!vld_q || PWR_RDY) begin
        vld_d = 1'b1;
        pwr_d = res_pwr_q;
        pk_d  = res_pk_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (vld_q && PWR_RDY) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= 1'b0;
      pwr_q <= {PW{1'b0}};
      pk_q  <= {PW{1'b0}};
      ovf_q <= 1'b0;
    end else if (CLR) begin
      vld_q <= 1'b0;
      pwr_q <= {PW{1'b0}};
      pk_q  <= {PW{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      pwr_q <= pwr_d;
      pk_q  <= pk_d;
      ovf_q <= ovf_d;
    end
  end

  assign PWR_VLD  = vld_q;
  assign PWR_DAT  = pwr_q;
  assign PEAK_DAT = pk_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_ddc_pwr_det.sv
// Directed bench for ddc_pwr_det with N=4: table of windows plus hand sequences
// for backpressure/overflow, clear and asynchronous reset.
module tb_ddc_pwr_det;

  logic        CLK = 1'b0;
  logic        RST, CLR, DIN_OE, PWR_RDY;
  logic [15:0] DIN_I, DIN_Q;
  logic        PWR_VLD, OVF;
  logic [31:0] PWR_DAT, PEAK_DAT;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [0:3][15:0] i_v;
    logic [0:3][15:0] q_v;
    logic [0:2][3:0]  gap_v;
    logic [31:0]      exp_pwr;
    logic [31:0]      exp_pk;
  } vec_t;

  vec_t vecs [6];

  ddc_pwr_det #(.DW(16), .LOG2N(2)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .DIN_OE(DIN_OE),
    .DIN_I(DIN_I), .DIN_Q(DIN_Q), .PWR_VLD(PWR_VLD), .PWR_RDY(PWR_RDY),
    .PWR_DAT(PWR_DAT), .PEAK_DAT(PEAK_DAT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    DIN_OE = 1'b0;
    DIN_I  = 16'($urandom);
    DIN_Q  = 16'($urandom);
  endtask

  task automatic put_sample(input logic [15:0] i, input logic [15:0] q);
    @(negedge CLK);
    DIN_OE = 1'b1;
    DIN_I  = i;
    DIN_Q  = q;
  endtask

  // Drives one window, then checks latency, single-cycle valid and data.
  task automatic run_window(input vec_t v, input string nm);
    for (int k = 0; k < 4; k++) begin
      put_sample(v.i_v[k], v.q_v[k]);
      if (k < 3) begin
        for (int g = 0; g < int'(v.gap_v[k]); g++) begin
          @(negedge CLK);
          idle_inputs();
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      idle_inputs();
      chk({nm, "_vld"}, {63'd0, PWR_VLD}, (k == 3) ? 64'd1 : 64'd0);
      if (k == 3) begin
        chk({nm, "_pwr"}, {32'd0, PWR_DAT}, {32'd0, v.exp_pwr});
        chk({nm, "_peak"}, {32'd0, PEAK_DAT}, {32'd0, v.exp_pk});
        chk({nm, "_ovf"}, {63'd0, OVF}, 64'd0);
      end
    end
  endtask

  vec_t one_v;

  initial begin
    vecs[0] = '{i_v: {16'd3, 16'd3, 16'd3, 16'd3}, q_v: {16'd4, 16'd4, 16'd4, 16'd4},
                gap_v: {4'd0, 4'd0, 4'd0}, exp_pwr: 32'd25, exp_pk: 32'd25};
    vecs[1] = '{i_v: {16'h8000, 16'h8000, 16'h8000, 16'h8000},
                q_v: {16'h8000, 16'h8000, 16'h8000, 16'h8000},
                gap_v: {4'd0, 4'd0, 4'd0}, exp_pwr: 32'h8000_0000, exp_pk: 32'h8000_0000};
    vecs[2] = '{i_v: {16'd0, 16'd0, 16'd0, 16'd0}, q_v: {16'd1, 16'd2, 16'd3, 16'd4},
                gap_v: {4'd0, 4'd3, 4'd7}, exp_pwr: 32'd7, exp_pk: 32'd16};
    vecs[3] = '{i_v: {16'hFFFD, 16'd5, 16'hFFF9, 16'd0}, q_v: {16'd4, 16'hFFF4, 16'd0, 16'd0},
                gap_v: {4'd1, 4'd0, 4'd2}, exp_pwr: 32'd60, exp_pk: 32'd169};
    vecs[4] = '{i_v: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                q_v: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                gap_v: {4'd0, 4'd0, 4'd0}, exp_pwr: 32'h7FFE_0002, exp_pk: 32'h7FFE_0002};
    vecs[5] = '{i_v: {16'hFFFF, 16'd1, 16'd0, 16'd2}, q_v: {16'hFFFF, 16'd1, 16'd0, 16'hFFFE},
                gap_v: {4'd0, 4'd1, 4'd0}, exp_pwr: 32'd3, exp_pk: 32'd8};
    one_v   = '{i_v: {16'd1, 16'd1, 16'd1, 16'd1}, q_v: {16'd0, 16'd0, 16'd0, 16'd0},
                gap_v: {4'd0, 4'd0, 4'd0}, exp_pwr: 32'd1, exp_pk: 32'd1};

    // Reset held with inputs toggling: outputs stay zero.
    RST = 1'b0; CLR = 1'b0; PWR_RDY = 1'b0;
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      DIN_OE  = 1'($urandom);
      DIN_I   = 16'($urandom);
      DIN_Q   = 16'($urandom);
      CLR     = 1'($urandom);
      PWR_RDY = 1'($urandom);
      #1;
      chk("rst_outs", {PWR_VLD, OVF, PWR_DAT, PEAK_DAT}, 66'd0);
    end
    @(negedge CLK);
    idle_inputs();
    CLR = 1'b0; PWR_RDY = 1'b1;
    RST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      idle_inputs();
      chk("idle_vld", {63'd0, PWR_VLD}, 64'd0);
    end

    for (int v = 0; v < 6; v++) begin
      run_window(vecs[v], $sformatf("vec%0d", v));
    end

    // Backpressure: second window is dropped, first result held, OVF set.
    PWR_RDY = 1'b0;
    put_sample(16'd2, 16'd0); put_sample(16'd4, 16'd0);
    put_sample(16'd6, 16'd0); put_sample(16'd8, 16'd0);
    for (int k = 0; k < 4; k++) put_sample(16'd1, 16'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      idle_inputs();
      if (k == 0) begin
        chk("bp_vld0", {63'd0, PWR_VLD}, 64'd1);
        chk("bp_pwr0", {32'd0, PWR_DAT}, 64'd30);
        chk("bp_ovf0", {63'd0, OVF}, 64'd0);
      end
    end
    chk("bp_vld", {63'd0, PWR_VLD}, 64'd1);
    chk("bp_pwr", {32'd0, PWR_DAT}, 64'd30);
    chk("bp_peak", {32'd0, PEAK_DAT}, 64'd64);
    chk("bp_ovf", {63'd0, OVF}, 64'd1);
    PWR_RDY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      idle_inputs();
      chk("bp_drain_vld", {63'd0, PWR_VLD}, 64'd0);
      chk("bp_ovf_sticky", {63'd0, OVF}, 64'd1);
    end
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_ovf", {63'd0, OVF}, 64'd0);

    // CLR together with a third sample discards the partial window.
    put_sample(16'd100, 16'd0);
    put_sample(16'd100, 16'd0);
    put_sample(16'd100, 16'd0);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    idle_inputs();
    run_window(one_v, "clr_win");

    // Asynchronous reset mid-window discards the partial window.
    put_sample(16'd100, 16'd0);
    put_sample(16'd100, 16'd0);
    put_sample(16'd100, 16'd0);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_outs", {PWR_VLD, OVF, PWR_DAT, PEAK_DAT}, 66'd0);
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    run_window(one_v, "rst_win");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
